// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver. It samples a two-flop-synchronised serial line on an
// oversampled baud strobe and presents each received byte on a valid/ready handshake.
// It raises one-cycle pulses for a framing error (stop bit low) and for an overrun
// (an unaccepted byte was overwritten).
module uart_rx #(
  parameter int OVERSAMPLE = 8,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic                 rx_serial,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_busy,
  output logic                 framing_error,
  output logic                 overrun
);

  localparam int SCNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BCNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [SCNT_W-1:0] SCNT_ZERO = {SCNT_W{1'b0}};
  localparam logic [SCNT_W-1:0] SCNT_ONE  = SCNT_W'(1);
  localparam logic [SCNT_W-1:0] SCNT_MID  = SCNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(OVERSAMPLE - 1);
  localparam logic [BCNT_W-1:0] BCNT_ZERO = {BCNT_W{1'b0}};
  localparam logic [BCNT_W-1:0] BCNT_ONE  = BCNT_W'(1);
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_e;

  logic [1:0]           sync_q;
  logic                 rx_s;
  state_e               state_q,   state_d;
  logic [SCNT_W-1:0]    scnt_q,    scnt_d;
  logic [BCNT_W-1:0]    bcnt_q,    bcnt_d;
  logic [DATA_BITS-1:0] shreg_q,   shreg_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 busy_q,    busy_d;
  logic                 fe_q,      fe_d;
  logic                 ovr_q,     ovr_d;

  // Synchronised view of the serial line; everything downstream uses only this.
  assign rx_s = sync_q[1];

  // Two-flop synchroniser for the asynchronous serial input; idles high out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx_serial};
    end
  end

  // Next-state logic: frame FSM advances only on baud ticks; the handshake runs every cycle.
  always_comb begin
    state_d   = state_q;
    scnt_d    = scnt_q;
    bcnt_d    = bcnt_q;
    shreg_d   = shreg_q;
    rx_data_d = rx_data_q;
    fe_d      = 1'b0;
    ovr_d     = 1'b0;

    // An accepted byte drops valid; a byte completing this cycle overrides this below.
    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end else begin
      rx_valid_d = rx_valid_q;
    end

    if (baud_tick) begin
      case (state_q)
        ST_IDLE: begin
          if (!rx_s) begin
            scnt_d  = SCNT_ZERO;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_START: begin
          // Re-check the line halfway into the start bit to reject glitches.
          if (scnt_q == SCNT_MID) begin
            if (rx_s) begin
              state_d = ST_IDLE;
            end else begin
              scnt_d  = SCNT_ZERO;
              bcnt_d  = BCNT_ZERO;
              state_d = ST_DATA;
            end
          end else begin
            scnt_d = scnt_q + SCNT_ONE;
          end
        end
        ST_DATA: begin
          if (scnt_q == SCNT_LAST) begin
            shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
            scnt_d  = SCNT_ZERO;
            if (bcnt_q == BCNT_LAST) begin
              state_d = ST_STOP;
            end else begin
              bcnt_d = bcnt_q + BCNT_ONE;
            end
          end else begin
            scnt_d = scnt_q + SCNT_ONE;
          end
        end
        ST_STOP: begin
          // Leave at mid stop bit so a back-to-back start edge is not missed.
          if (scnt_q == SCNT_LAST) begin
            scnt_d  = SCNT_ZERO;
            state_d = ST_IDLE;
            if (rx_s) begin
              rx_data_d  = shreg_q;
              rx_valid_d = 1'b1;
              // Overrun only when the old byte is still pending and not taken this cycle.
              ovr_d      = rx_valid_q && !rx_ready;
            end else begin
              fe_d = 1'b1;
            end
          end else begin
            scnt_d = scnt_q + SCNT_ONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State, datapath and registered outputs, with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      scnt_q     <= SCNT_ZERO;
      bcnt_q     <= BCNT_ZERO;
      shreg_q    <= {DATA_BITS{1'b0}};
      rx_data_q  <= {DATA_BITS{1'b0}};
      rx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      fe_q       <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      scnt_q     <= scnt_d;
      bcnt_q     <= bcnt_d;
      shreg_q    <= shreg_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      busy_q     <= busy_d;
      fe_q       <= fe_d;
      ovr_q      <= ovr_d;
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_busy       = busy_q;
  assign framing_error = fe_q;
  assign overrun       = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx. Stimulus tasks push expected events
// (byte accepted, framing error, overrun) from a frame-level model; a monitor on
// the falling edge pops and compares whenever the DUT reports one of those events.
module tb_uart_rx;

  localparam int BIT_CLKS = 32;
  localparam int EV_BYTE  = 0;
  localparam int EV_FE    = 1;
  localparam int EV_OVR   = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       baud_tick = 1'b0;
  logic       rx_serial = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       framing_error;
  logic       overrun;

  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  ev_t        exp_q[$];

  // frame-level model state: byte held by the receiver and not yet taken
  logic [7:0] pend = 8'h00;
  bit         pend_v = 1'b0;
  logic [7:0] last_byte = 8'h00;

  uart_rx #(.OVERSAMPLE(8), .DATA_BITS(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .baud_tick     (baud_tick),
    .rx_serial     (rx_serial),
    .rx_ready      (rx_ready),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_busy       (rx_busy),
    .framing_error (framing_error),
    .overrun       (overrun)
  );

  initial forever #5 clk = ~clk;

  // cycle counter and a baud strobe every 4 clocks
  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      #1;
      baud_tick = (cyc % 4 == 0);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog got=still_running exp=finished");
    $fatal(1);
  end

  function automatic string kname(int k);
    case (k)
      EV_BYTE: return "byte";
      EV_FE:   return "framing_error";
      EV_OVR:  return "overrun";
      default: return "none";
    endcase
  endfunction

  task automatic check(string name, int got, int exp);
    n_checks = n_checks + 1;
    if (got != exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic push(int k, logic [7:0] d);
    ev_t e;
    e.kind = k;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic mon_event(int k, logic [7:0] d);
    ev_t e;
    n_checks = n_checks + 1;
    if (exp_q.size() == 0) begin
      n_fail = n_fail + 1;
      $display("FAIL sb_unexpected got=%s/%h exp=nothing at cyc %0d", kname(k), d, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || (k == EV_BYTE && e.data !== d)) begin
        n_fail = n_fail + 1;
        $display("FAIL sb_event got=%s/%h exp=%s/%h at cyc %0d",
                 kname(k), d, kname(e.kind), e.data, cyc);
      end
    end
  endtask

  // monitor: report every DUT event to the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (framing_error) mon_event(EV_FE, 8'h00);
        if (overrun) mon_event(EV_OVR, 8'h00);
        if (rx_valid && rx_ready) mon_event(EV_BYTE, rx_data);
      end
    end
  end

  // model of one frame: ready = consumer ready at completion, coincide = accept lands on completion
  task automatic model_frame(logic [7:0] d, bit stop, bit ready, bit coincide);
    if (!stop) begin
      push(EV_FE, 8'h00);
    end else begin
      last_byte = d;
      if (pend_v) begin
        if (coincide) push(EV_BYTE, pend);
        else push(EV_OVR, 8'h00);
        pend = d;
      end else if (ready) begin
        push(EV_BYTE, d);
      end else begin
        pend   = d;
        pend_v = 1'b1;
      end
    end
  endtask

  task automatic model_release();
    if (pend_v) push(EV_BYTE, pend);
    pend_v = 1'b0;
  endtask

  task automatic clks(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic align4();
    while (cyc % 4 != 0) clks(1);
  endtask

  task automatic send_frame(logic [7:0] d, bit stop);
    rx_serial = 1'b0;
    clks(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rx_serial = d[i];
      clks(BIT_CLKS);
    end
    rx_serial = stop;
    clks(BIT_CLKS);
    rx_serial = 1'b1;
  endtask

  task automatic drain(string name, int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    int  calib_l;
    int  cs;
    int  target;
    bit  seen;
    bit  ok;
    logic [7:0] d;
    bit  stop;
    int  gap;

    calib_l = 0;
    clks(5);
    check("reset_data", int'(rx_data), 0);
    check("reset_valid", int'(rx_valid), 0);
    check("reset_busy", int'(rx_busy), 0);
    check("reset_fe", int'(framing_error), 0);
    check("reset_ovr", int'(overrun), 0);
    rst = 1'b0;
    clks(10);

    // 1: clean 0xA5 with consumer ready; valid is a single-cycle pulse
    rx_ready = 1'b1;
    model_frame(8'hA5, 1'b1, 1'b1, 1'b0);
    fork
      send_frame(8'hA5, 1'b1);
      begin
        ok = 1'b0;
        for (int k = 0; k < 500; k++) begin
          @(negedge clk);
          if (rx_valid) begin
            ok = 1'b1;
            break;
          end
        end
        check("t1_valid_seen", int'(ok), 1);
        @(negedge clk);
        check("t1_valid_pulse", int'(rx_valid), 0);
      end
    join
    clks(40);
    drain("t1_drain", 200);

    // 2: 8-clock low glitch is a false start
    rx_serial = 1'b0;
    clks(8);
    rx_serial = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (rx_busy) seen = 1'b1;
    end
    check("t2_busy_seen", int'(seen), 1);
    check("t2_busy_dropped", int'(rx_busy), 0);
    check("t2_valid", int'(rx_valid), 0);

    // 3: stop bit low -> framing error, data untouched
    model_frame(8'h3C, 1'b0, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b0);
    clks(48);
    drain("t3_drain", 200);
    check("t3_data_kept", int'(rx_data), int'(last_byte));
    check("t3_valid", int'(rx_valid), 0);

    // 4: two back-to-back bytes with consumer stalled -> overrun, second byte kept
    rx_ready = 1'b0;
    model_frame(8'h11, 1'b1, 1'b0, 1'b0);
    model_frame(8'h22, 1'b1, 1'b0, 1'b0);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    clks(20);
    check("t4_valid", int'(rx_valid), 1);
    check("t4_data", int'(rx_data), 32'h22);
    drain("t4_drain_ovr", 200);
    model_release();
    rx_ready = 1'b1;
    clks(1);
    check("t4_valid_cleared", int'(rx_valid), 0);
    drain("t4_drain", 50);

    // 5: reset in the middle of a 0xFF frame, then a clean 0x5A
    fork
      send_frame(8'hFF, 1'b1);
      begin
        clks(BIT_CLKS * 4);
        rst = 1'b1;
        clks(1);
        rst = 1'b0;
        check("t5_data", int'(rx_data), 0);
        check("t5_valid", int'(rx_valid), 0);
        check("t5_busy", int'(rx_busy), 0);
        check("t5_fe", int'(framing_error), 0);
        check("t5_ovr", int'(overrun), 0);
        pend_v    = 1'b0;
        last_byte = 8'h00;
      end
    join
    clks(40);
    model_frame(8'h5A, 1'b1, 1'b1, 1'b0);
    send_frame(8'h5A, 1'b1);
    clks(40);
    drain("t5_drain", 200);
    check("t5_data_after", int'(rx_data), 32'h5A);

    // 6: measure completion offset, then accept the pending byte exactly when 0x81 lands
    rx_ready = 1'b1;
    align4();
    cs = cyc;
    d  = 8'($urandom);
    model_frame(d, 1'b1, 1'b1, 1'b0);
    fork
      send_frame(d, 1'b1);
      begin
        seen = 1'b0;
        for (int k = 0; k < 600; k++) begin
          @(negedge clk);
          if (rx_busy) begin
            seen = 1'b1;
          end else if (seen) begin
            calib_l = cyc - cs;
            break;
          end
        end
      end
    join
    check("t6_calib_found", int'(calib_l > 0), 1);
    clks(40);
    drain("t6_calib_drain", 200);

    rx_ready = 1'b0;
    align4();
    cs = cyc;
    d  = 8'($urandom);
    model_frame(d, 1'b1, 1'b0, 1'b0);
    model_frame(8'h81, 1'b1, 1'b1, 1'b1);
    target = cs + 10 * BIT_CLKS + calib_l - 1;
    fork
      begin
        send_frame(d, 1'b1);
        send_frame(8'h81, 1'b1);
      end
      begin
        for (int k = 0; k < 3000 && cyc < target; k++) clks(1);
        check("t6_align", cyc, target);
        rx_ready = 1'b1;
        clks(1);
        rx_ready = 1'b0;
      end
    join
    clks(20);
    check("t6_valid", int'(rx_valid), 1);
    check("t6_data", int'(rx_data), 32'h81);
    drain("t6_drain_first", 200);
    model_release();
    rx_ready = 1'b1;
    clks(2);
    drain("t6_drain", 50);

    // random frames, about a quarter with a bad stop bit
    for (int n = 0; n < 24; n++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      model_frame(d, stop, 1'b1, 1'b0);
      send_frame(d, stop);
      gap = stop ? $urandom_range(0, 24) : $urandom_range(32, 60);
      if (gap > 0) clks(gap);
    end
    clks(40);
    drain("rand_drain", 2000);
    check("rand_last_data", int'(rx_data), int'(last_byte));

    // break: line low long enough for exactly two frame times, each a framing error
    push(EV_FE, 8'h00);
    push(EV_FE, 8'h00);
    rx_serial = 1'b0;
    clks(624);
    rx_serial = 1'b1;
    clks(100);
    drain("break_drain", 500);
    check("break_valid", int'(rx_valid), 0);
    check("break_busy", int'(rx_busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
